piece_bag_generator: RTL and testbench

Parametrised piece randomiser with a preview queue. Generates piece indices from a Galois LFSR in either uniform mode or "bag" mode, where every aligned group of NUM_PIECES outputs is a permutation of all pieces. Holds up to PREVIEW_DEPTH upcoming pieces for the spawn logic and next-piece display. Successor to the fixed 3-bit modulo generator: it adds configurable piece count, preview depth, LFSR width, runtime seeding and a valid/take handshake.

---
 rtl/piece_gen_pkg.sv | 23 ++
 rtl/piece_bag_generator_lfsr.sv | 22 ++
 rtl/piece_bag_generator.sv | 160 ++++++++++++++++
 tb/tb_piece_bag_generator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_gen_pkg.sv
// Shared types, LFSR tap table and helpers for the piece randomiser.
package piece_gen_pkg;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [23:0] TAPS_24 = 24'hE10000;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Widest piece index the spawn logic ever handles (16 piece types).
    localparam int unsigned MAX_PIECE_W = 4;
    typedef logic [MAX_PIECE_W-1:0] piece_idx_t;

    // Maximal-length Galois tap mask for a supported LFSR width.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'(TAPS_8);
            16:      return 32'(TAPS_16);
            24:      return 32'(TAPS_24);
            default: return TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/piece_bag_generator_lfsr.sv
// Right-shifting Galois LFSR; reset and load both capture load_value.
module galois_lfsr #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h0000B400)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state
);

    // The owner supplies the reset seed on load_value, so reset behaves as a load.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            state <= load_value;
        end else begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/piece_bag_generator.sv
// Piece randomiser: LFSR candidates feed a preview queue, uniform or 7-bag style.
module piece_bag_generator
    import piece_gen_pkg::*;
#(
    parameter int unsigned NUM_PIECES    = 7,
    parameter int unsigned PREVIEW_DEPTH = 3,
    parameter int unsigned LFSR_WIDTH    = 16,
    parameter logic [31:0] SEED          = 32'h0000ACE1,
    localparam int unsigned PIECE_W      = $clog2(NUM_PIECES),
    localparam int unsigned CNT_W        = $clog2(PREVIEW_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               bag_mode,
    input  logic                               take,
    input  logic                               seed_load,
    input  logic [LFSR_WIDTH-1:0]              seed_value,
    output logic                               piece_valid,
    output logic [PIECE_W-1:0]                 next_piece,
    output logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview,
    output logic [CNT_W-1:0]                   preview_count,
    output logic [NUM_PIECES-1:0]              bag_remaining
);

    localparam logic [LFSR_WIDTH-1:0] SEED_L    = LFSR_WIDTH'(SEED);
    localparam logic [LFSR_WIDTH-1:0] TAPS      = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));
    localparam logic [NUM_PIECES-1:0] FULL_MASK = '1;
    localparam logic [PIECE_W:0]      NUM_LIM   = (PIECE_W + 1)'(NUM_PIECES);
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(PREVIEW_DEPTH);

    logic [LFSR_WIDTH-1:0] lfsr;
    logic [LFSR_WIDTH-1:0] lfsr_load_value;
    logic                  lfsr_unused;

    logic [PIECE_W-1:0]    q   [PREVIEW_DEPTH];
    logic [PIECE_W-1:0]    q_n [PREVIEW_DEPTH];
    logic [CNT_W-1:0]      count_n;
    logic [CNT_W-1:0]      count_after_pop;
    logic [NUM_PIECES-1:0] mask_eff;
    logic [NUM_PIECES-1:0] mask_n;
    logic [PIECE_W-1:0]    cand;
    logic [PIECE_W-1:0]    push_piece;
    piece_idx_t            last_free;
    logic                  bag_mode_q;
    logic                  pop;
    logic                  push;
    logic                  in_range;
    logic                  cand_free;

    // A zero runtime seed would lock the LFSR, so it falls back to SEED.
    assign lfsr_load_value = (reset || (seed_value == '0)) ? SEED_L : seed_value;

    galois_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (seed_load),
        .load_value (lfsr_load_value),
        .state      (lfsr)
    );

    assign cand        = lfsr[PIECE_W-1:0];
    assign lfsr_unused = ^lfsr[LFSR_WIDTH-1:PIECE_W];

    // Pop, candidate qualification, push and bag-mask bookkeeping for this cycle.
    always_comb begin
        pop             = take && (preview_count != '0);
        count_after_pop = preview_count - CNT_W'(pop);
        mask_eff        = (bag_mode != bag_mode_q) ? FULL_MASK : bag_remaining;
        in_range        = {1'b0, cand} < NUM_LIM;
        cand_free       = 1'b0;
        last_free       = '0;
        for (int unsigned k = 0; k < NUM_PIECES; k++) begin
            if (mask_eff[k]) begin
                last_free = piece_idx_t'(k);
                if (PIECE_W'(k) == cand) begin
                    cand_free = 1'b1;
                end
            end
        end

        push       = 1'b0;
        push_piece = cand;
        if (count_after_pop < DEPTH_C) begin
            if (!bag_mode) begin
                push = in_range;
            end else if ($onehot(mask_eff)) begin
                push       = 1'b1;
                push_piece = PIECE_W'(last_free);
            end else begin
                push = cand_free;
            end
        end

        for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
            q_n[i] = q[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i + 1 < PREVIEW_DEPTH; i++) begin
                q_n[i] = q[i+1];
            end
            q_n[PREVIEW_DEPTH-1] = '0;
        end
        for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
            if (push && (CNT_W'(i) == count_after_pop)) begin
                q_n[i] = push_piece;
            end
        end
        count_n = count_after_pop + CNT_W'(push);

        mask_n = mask_eff;
        if (bag_mode && push) begin
            for (int unsigned k = 0; k < NUM_PIECES; k++) begin
                if (PIECE_W'(k) == push_piece) begin
                    mask_n[k] = 1'b0;
                end
            end
            if (mask_n == '0) begin
                mask_n = FULL_MASK;
            end
        end

        if (seed_load) begin
            for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
                q_n[i] = '0;
            end
            count_n = '0;
            mask_n  = FULL_MASK;
        end
    end

    // Queue, count, valid flag and bag mask registers.
    always_ff @(posedge clk) begin
        bag_mode_q <= bag_mode;
        if (reset) begin
            for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
                q[i] <= '0;
            end
            preview_count <= '0;
            piece_valid   <= 1'b0;
            bag_remaining <= FULL_MASK;
        end else begin
            for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
                q[i] <= q_n[i];
            end
            preview_count <= count_n;
            piece_valid   <= (count_n != '0);
            bag_remaining <= mask_n;
        end
    end

    assign next_piece = q[0];

    for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
        assign preview[g*PIECE_W +: PIECE_W] = q[g];
    end

endmodule

// File: tb/tb_piece_bag_generator.sv
// Bench for piece_bag_generator: default configuration plus a 5-piece/depth-1/8-bit one.
module tb_piece_bag_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, bag_mode, take, seed_load;
    logic [15:0] seed_value;
    logic        piece_valid;
    logic [2:0]  next_piece;
    logic [8:0]  preview;
    logic [1:0]  preview_count;
    logic [6:0]  bag_remaining;

    logic        bag_mode_b, take_b, seed_load_b;
    logic [7:0]  seed_value_b;
    logic        piece_valid_b;
    logic [2:0]  next_piece_b;
    logic [2:0]  preview_b;
    logic [0:0]  preview_count_b;
    logic [4:0]  bag_remaining_b;

    piece_bag_generator dut_a (
        .clk(clk), .reset(reset), .bag_mode(bag_mode), .take(take),
        .seed_load(seed_load), .seed_value(seed_value),
        .piece_valid(piece_valid), .next_piece(next_piece), .preview(preview),
        .preview_count(preview_count), .bag_remaining(bag_remaining)
    );

    piece_bag_generator #(.NUM_PIECES(5), .PREVIEW_DEPTH(1), .LFSR_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .bag_mode(bag_mode_b), .take(take_b),
        .seed_load(seed_load_b), .seed_value(seed_value_b),
        .piece_valid(piece_valid_b), .next_piece(next_piece_b), .preview(preview_b),
        .preview_count(preview_count_b), .bag_remaining(bag_remaining_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rec_a = 1'b0;
    int pops_a[$];
    int pops_b[$];

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int          p_num[2]   = '{7, 5};
    int          p_depth[2] = '{3, 1};
    int          p_pw[2]    = '{3, 3};
    logic [31:0] p_taps[2]  = '{32'hB400, 32'hB8};
    logic [31:0] p_seed[2]  = '{32'hACE1, 32'hE1};
    logic [31:0] m_lfsr[2];
    int          m_q[2][8];
    int          m_cnt[2];
    int          m_mask[2];
    bit          m_modeq[2];
    int          m_short[2] = '{0, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int id, input bit rst, input bit bm, input bit tk,
                              input bit sl, input logic [31:0] sv);
        int  full, cand, m, piece;
        bit  acc;
        full = (1 << p_num[id]) - 1;
        if (rst || sl) begin
            m_lfsr[id] = (rst || sv == 0) ? p_seed[id] : sv;
            m_cnt[id]  = 0;
            for (int i = 0; i < 8; i++) m_q[id][i] = 0;
            m_mask[id]  = full;
            m_modeq[id] = bm;
            return;
        end
        cand = int'(m_lfsr[id]) % (1 << p_pw[id]);
        if (tk && m_cnt[id] > 0) begin
            for (int i = 0; i < p_depth[id] - 1; i++) m_q[id][i] = m_q[id][i+1];
            m_q[id][p_depth[id]-1] = 0;
            m_cnt[id]--;
        end
        m     = (bm != m_modeq[id]) ? full : m_mask[id];
        acc   = 1'b0;
        piece = cand;
        if (m_cnt[id] < p_depth[id]) begin
            if (!bm) begin
                acc = cand < p_num[id];
            end else if ($countones(m) == 1) begin
                acc = 1'b1;
                for (int k = 0; k < p_num[id]; k++) if (m[k]) piece = k;
                m_short[id]++;
            end else begin
                acc = (cand < p_num[id]) && m[cand];
            end
        end
        if (acc) begin
            m_q[id][m_cnt[id]] = piece;
            m_cnt[id]++;
            if (bm) begin
                m = m & ~(1 << piece);
                if (m == 0) m = full;
            end
        end
        m_mask[id]  = m;
        m_lfsr[id]  = (m_lfsr[id] >> 1) ^ (m_lfsr[id][0] ? p_taps[id] : 32'h0);
        m_modeq[id] = bm;
    endtask

    function automatic logic [63:0] model_preview(input int id);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < p_depth[id]; i++) r = r | (64'(m_q[id][i]) << (i * p_pw[id]));
        return r;
    endfunction

    task automatic compare_all();
        check("a_valid",   64'(piece_valid),     64'(m_cnt[0] > 0));
        check("a_next",    64'(next_piece),      64'(m_q[0][0]));
        check("a_preview", 64'(preview),         model_preview(0));
        check("a_count",   64'(preview_count),   64'(m_cnt[0]));
        check("a_mask",    64'(bag_remaining),   64'(m_mask[0]));
        check("b_valid",   64'(piece_valid_b),   64'(m_cnt[1] > 0));
        check("b_next",    64'(next_piece_b),    64'(m_q[1][0]));
        check("b_preview", 64'(preview_b),       model_preview(1));
        check("b_count",   64'(preview_count_b), 64'(m_cnt[1]));
        check("b_mask",    64'(bag_remaining_b), 64'(m_mask[1]));
    endtask

    // One clock: record pops, advance the model on the edge, compare on the falling edge.
    task automatic step();
        take_b = (cyc % 3) != 0;
        cyc++;
        if (rec_a && !reset && !seed_load && take && piece_valid) pops_a.push_back(int'(next_piece));
        if (!reset && take_b && piece_valid_b && pops_b.size() < 600) pops_b.push_back(int'(next_piece_b));
        @(posedge clk);
        model_step(0, reset, bag_mode, take, seed_load, 32'(seed_value));
        model_step(1, reset, bag_mode_b, take_b, seed_load_b, 32'(seed_value_b));
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int seen;
        int hist[8];
        int bad_b;
        reset = 1'b1; bag_mode = 1'b1; take = 1'b1; seed_load = 1'b0; seed_value = '0;
        bag_mode_b = 1'b1; take_b = 1'b0; seed_load_b = 1'b0; seed_value_b = '0;

        // Reset held with take asserted: outputs stay at reset values.
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_valid", 64'(piece_valid), 64'(0));
            check("rst_next",  64'(next_piece), 64'(0));
            check("rst_prev",  64'(preview), 64'(0));
            check("rst_count", 64'(preview_count), 64'(0));
            check("rst_mask",  64'(bag_remaining), 64'h7F);
            check("rst_mask_b", 64'(bag_remaining_b), 64'h1F);
        end

        // First pieces after release: seed 0xACE1 gives candidates 1,0,0,4,6,...
        reset = 1'b0; take = 1'b0;
        step();
        check("first_valid", 64'(piece_valid), 64'(1));
        check("first_next",  64'(next_piece), 64'(1));
        check("first_b_next", 64'(next_piece_b), 64'(1));
        step();
        check("second_count", 64'(preview_count), 64'(2));
        check("second_prev",  64'(preview), 64'h001);
        check("second_mask",  64'(bag_remaining), 64'h7C);

        // Zero seed mid-stream flushes and restarts from SEED.
        seed_load = 1'b1; seed_value = 16'h0000;
        step();
        seed_load = 1'b0;
        check("sl_count", 64'(preview_count), 64'(0));
        check("sl_valid", 64'(piece_valid), 64'(0));
        check("sl_mask",  64'(bag_remaining), 64'h7F);
        check("sl_prev",  64'(preview), 64'(0));
        step();
        check("resq1_next", 64'(next_piece), 64'(1));
        check("resq1_mask", 64'(bag_remaining), 64'h7D);
        step();
        check("resq2_mask", 64'(bag_remaining), 64'h7C);
        step();
        check("resq3_count", 64'(preview_count), 64'(2));
        step();
        check("full_count", 64'(preview_count), 64'(3));
        check("full_prev",  64'(preview), 64'h101);
        check("full_mask",  64'(bag_remaining), 64'h6C);

        // Full queue with take: pop and push in the same edge.
        take = 1'b1;
        step();
        check("fulltake_count", 64'(preview_count), 64'(3));
        check("fulltake_next",  64'(next_piece), 64'(0));
        check("fulltake_prev",  64'(preview), 64'h1A0);
        check("fulltake_mask",  64'(bag_remaining), 64'h2C);

        // Take while empty is ignored; refill proceeds as usual.
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        check("empty_count0", 64'(preview_count), 64'(0));
        step();
        check("empty_take_count", 64'(preview_count), 64'(1));
        check("empty_take_next",  64'(next_piece), 64'(1));

        // Bag mode, take every cycle: aligned groups of 7 are permutations.
        seed_load = 1'b1; seed_value = 16'h1234;
        step();
        seed_load = 1'b0;
        pops_a.delete();
        rec_a = 1'b1;
        for (int c = 0; c < 6000 && pops_a.size() < 700; c++) step();
        check("bag_pop_budget", 64'(pops_a.size() >= 700), 64'(1));
        for (int g = 0; g < 100 && (g * 7 + 6) < pops_a.size(); g++) begin
            seen = 0;
            for (int j = 0; j < 7; j++) seen = seen | (1 << pops_a[g*7+j]);
            check("bag_perm7", 64'(seen), 64'h7F);
        end

        // Switch to uniform mode, then reseed and draw 10000 pieces.
        rec_a = 1'b0;
        bag_mode = 1'b0;
        step();
        seed_load = 1'b1; seed_value = 16'hBEEF;
        step();
        seed_load = 1'b0;
        pops_a.delete();
        rec_a = 1'b1;
        for (int c = 0; c < 20000 && pops_a.size() < 10000; c++) step();
        rec_a = 1'b0;
        check("uni_pop_budget", 64'(pops_a.size() >= 10000), 64'(1));
        for (int v = 0; v < 8; v++) hist[v] = 0;
        for (int i = 0; i < 10000 && i < pops_a.size(); i++) hist[pops_a[i]]++;
        check("uni_never7", 64'(hist[7]), 64'(0));
        for (int v = 0; v < 7; v++) begin
            check("uni_hist", 64'(hist[v] >= 1214 && hist[v] <= 1642), 64'(1));
        end

        // Five-piece bag configuration observed throughout the run.
        bad_b = 0;
        foreach (pops_b[i]) if (pops_b[i] >= 5) bad_b++;
        check("b_range", 64'(bad_b), 64'(0));
        check("b_pop_budget", 64'(pops_b.size() >= 500), 64'(1));
        for (int g = 0; g < 100 && (g * 5 + 4) < pops_b.size(); g++) begin
            seen = 0;
            for (int j = 0; j < 5; j++) seen = seen | (1 << pops_b[g*5+j]);
            check("b_perm5", 64'(seen), 64'h1F);
        end
        check("b_shortcut_used", 64'(m_short[1] > 0), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
